uart_cmd_parser: RTL and testbench
==================================

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16: maximum payload bytes per frame (1..255).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 100000: inter-byte timeout in sysclk cycles.
REQ-003 SHALL have parameter LED_ADDR, default 8'h00: register address mirrored onto led.
REQ-004 SHALL have port: sysclk  in  1  system clock; all logic on rising edge.
REQ-005 SHALL have port: rstn  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port: rx_data  in  8  received byte from UART receiver.
REQ-007 SHALL have port: rx_valid  in  1  one-cycle strobe, rx_data valid.
REQ-008 SHALL have port: reg_wr_en  out  1  register write strobe.
REQ-009 SHALL have port: reg_wr_addr  out  8  write address.
REQ-010 SHALL have port: reg_wr_data  out  8  write data.
REQ-011 SHALL have port: frame_ok  out  1  one-cycle pulse, frame committed.
REQ-012 SHALL have port: frame_err  out  1  one-cycle pulse, frame discarded.
REQ-013 SHALL have port: busy  out  1  high while in COMMIT.
REQ-014 SHALL have port: led  out  4  low nibble of last data written to LED_ADDR.

Function
REQ-015 SHALL parse frames: header 8'hA5, ADDR, LEN, LEN payload bytes, CSUM.
REQ-016 SHALL use states IDLE, ADDR, LEN, DATA, CSUM, COMMIT; one byte consumed per rx_valid.
REQ-017 IDLE: on 8'hA5 go to ADDR; any other byte ignored, no frame_err.
REQ-018 LEN of 0 or > MAX_LEN SHALL pulse frame_err the following cycle and return to IDLE.
REQ-019 Payload bytes SHALL be stored in a MAX_LEN x 8 buffer, index 0 upward.
REQ-020 CSUM SHALL equal the mod-256 sum of ADDR, LEN and all payload bytes; the running sum is 8 bits, wrapping.
REQ-021 On CSUM mismatch: frame_err pulses the cycle after the CSUM byte, no writes, back to IDLE.
REQ-022 On CSUM match: enter COMMIT the cycle after the CSUM byte; write i (i=0..LEN-1) asserts reg_wr_en in COMMIT cycle i with addr ADDR+i (8-bit wrap) and data buffer[i].
REQ-023 frame_ok SHALL pulse the cycle after the last write, with the state returning to IDLE the same cycle.
REQ-024 busy SHALL be high exactly during the LEN COMMIT cycles.
REQ-025 rx_valid during COMMIT SHALL be dropped, with no effect on parsing.
REQ-026 led SHALL update to reg_wr_data[3:0] on the cycle after any write with reg_wr_addr==LED_ADDR.
REQ-027 Writes SHALL occur only for checksum-valid frames; no partial frame ever writes.

Reset
REQ-028 While rstn==0 at a clock edge: state IDLE; reg_wr_en, frame_ok, frame_err, busy = 0; reg_wr_addr, reg_wr_data = 0; led = 4'h0; checksum, index and timeout counter cleared.
REQ-029 Reset mid-frame or mid-COMMIT SHALL abort without further writes or pulses.

Configuration
REQ-030 Macro UART_CMD_TIMEOUT_EN defined: in ADDR/LEN/DATA/CSUM, TIMEOUT_CYC cycles without rx_valid SHALL pulse frame_err and return to IDLE; the counter restarts on every accepted byte.
REQ-031 Macro UART_CMD_TIMEOUT_EN undefined: no timeout counter synthesized; a partial frame waits indefinitely.

Structure
REQ-032 Package uart_cmd_pkg SHALL hold the state enum, the header constant 8'hA5, and the byte width.
REQ-033 The payload buffer SHALL be a sub-module uart_cmd_buf (write port, combinational read, parameter DEPTH=MAX_LEN).

Verification
REQ-034 A5 10 02 33 44 89 -> writes (10,33) then (11,44) on consecutive cycles; frame_ok pulses; busy high for 2 cycles.
REQ-035 A5 00 01 0B 0C -> single write (00,0B); led==4'hB.
REQ-036 A5 10 02 33 44 88 -> frame_err pulse; no reg_wr_en; led unchanged.
REQ-037 A5 20 00 and A5 20 11 (MAX_LEN=16) -> frame_err after the LEN byte each time; the next valid frame is accepted.
REQ-038 A5 FF 02 01 02 04 -> writes (FF,01), (00,02); address wraps.
REQ-039 With UART_CMD_TIMEOUT_EN: A5 10 then silence for TIMEOUT_CYC cycles -> frame_err; a following A5 00 01 05 06 sets led==4'h5.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - shared types and constants for the UART command parser
//
// Holds the byte width, the frame header value, the parser state enum and a
// helper that sizes buffer index ports.
package uart_cmd_pkg;

    localparam int BYTE_W = 8;
    localparam logic [BYTE_W-1:0] HDR_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        LEN    = 3'd2,
        DATA   = 3'd3,
        CSUM   = 3'd4,
        COMMIT = 3'd5
    } state_t;

    // Index width for a buffer of 'depth' entries; a single entry still needs one bit.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/uart_cmd_buf.sv
// rtl/uart_cmd_buf.sv - payload byte buffer, one write port, combinational read
//
// Ports:
//   sysclk  - clock, write on rising edge
//   wr_en   - write strobe
//   wr_addr - write index
//   wr_data - write byte
//   rd_addr - read index
//   rd_data - byte at rd_addr (combinational)
module uart_cmd_buf
    import uart_cmd_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = idx_width(DEPTH)
) (
    input  logic              sysclk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [BYTE_W-1:0] rd_data
);

    logic [BYTE_W-1:0] mem [DEPTH];

    always_ff @(posedge sysclk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - framed UART command parser driving a register write port
//
// Frame: A5, ADDR, LEN, LEN payload bytes, CSUM (mod-256 sum of ADDR, LEN, payload).
// A checksum-valid frame is replayed as LEN consecutive register writes starting
// at ADDR; anything else is discarded with a frame_err pulse.
//
// Build option: define UART_CMD_TIMEOUT_EN to abort a partial frame after
// TIMEOUT_CYC cycles without a received byte. Undefined, no counter exists.
//
// Ports:
//   sysclk      - clock, rising edge
//   rstn        - synchronous active-low reset
//   rx_data     - received byte
//   rx_valid    - one-cycle strobe qualifying rx_data
//   reg_wr_en   - register write strobe (high every COMMIT cycle)
//   reg_wr_addr - write address (ADDR + index, 8-bit wrap)
//   reg_wr_data - write data
//   frame_ok    - one-cycle pulse after the last write of a frame
//   frame_err   - one-cycle pulse when a frame is discarded
//   busy        - high while writes are being issued
//   led         - low nibble of the last byte written to LED_ADDR
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int              MAX_LEN     = 16,
    parameter int              TIMEOUT_CYC = 100000,
    parameter logic [BYTE_W-1:0] LED_ADDR  = 8'h00
) (
    input  logic              sysclk,
    input  logic              rstn,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              reg_wr_en,
    output logic [BYTE_W-1:0] reg_wr_addr,
    output logic [BYTE_W-1:0] reg_wr_data,
    output logic              frame_ok,
    output logic              frame_err,
    output logic              busy,
    output logic [3:0]        led
);

    localparam int                AW        = idx_width(MAX_LEN);
    localparam logic [BYTE_W-1:0] MAX_LEN_B = BYTE_W'(MAX_LEN);

    state_t            state, state_next;
    logic [BYTE_W-1:0] addr_q, len_q, idx_q, sum_q;
    logic              frame_ok_next, frame_err_next;
    logic              buf_we;
    logic [BYTE_W-1:0] buf_rd;
    logic              timeout_hit;

    uart_cmd_buf #(.DEPTH(MAX_LEN)) u_buf (
        .sysclk  (sysclk),
        .wr_en   (buf_we),
        .wr_addr (idx_q[AW-1:0]),
        .wr_data (rx_data),
        .rd_addr (idx_q[AW-1:0]),
        .rd_data (buf_rd)
    );

`ifdef UART_CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_q;
    logic          in_frame;

    assign in_frame = (state == ADDR) || (state == LEN) || (state == DATA) || (state == CSUM);

    // Counts idle cycles inside a frame; any accepted byte restarts it.
    always_ff @(posedge sysclk) begin
        if (!rstn || !in_frame || rx_valid) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + 1'b1;
        end
    end

    assign timeout_hit = in_frame && !rx_valid && (tmo_q == TW'(TIMEOUT_CYC - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
    assign timeout_hit        = 1'b0;
`endif

    always_ff @(posedge sysclk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        frame_ok_next  = 1'b0;
        frame_err_next = 1'b0;
        buf_we         = 1'b0;
        reg_wr_en      = 1'b0;
        reg_wr_addr    = '0;
        reg_wr_data    = '0;
        busy           = 1'b0;
        case (state)
            IDLE: begin
                if (rx_valid && rx_data == HDR_BYTE) begin
                    state_next = ADDR;
                end
            end
            ADDR: begin
                if (rx_valid) begin
                    state_next = LEN;
                end else if (timeout_hit) begin
                    state_next     = IDLE;
                    frame_err_next = 1'b1;
                end
            end
            LEN: begin
                if (rx_valid) begin
                    if (rx_data == '0 || rx_data > MAX_LEN_B) begin
                        state_next     = IDLE;
                        frame_err_next = 1'b1;
                    end else begin
                        state_next = DATA;
                    end
                end else if (timeout_hit) begin
                    state_next     = IDLE;
                    frame_err_next = 1'b1;
                end
            end
            DATA: begin
                if (rx_valid) begin
                    buf_we = 1'b1;
                    if (idx_q == len_q - 8'd1) begin
                        state_next = CSUM;
                    end
                end else if (timeout_hit) begin
                    state_next     = IDLE;
                    frame_err_next = 1'b1;
                end
            end
            CSUM: begin
                if (rx_valid) begin
                    if (rx_data == sum_q) begin
                        state_next = COMMIT;
                    end else begin
                        state_next     = IDLE;
                        frame_err_next = 1'b1;
                    end
                end else if (timeout_hit) begin
                    state_next     = IDLE;
                    frame_err_next = 1'b1;
                end
            end
            COMMIT: begin
                // rx_valid is ignored here; bytes arriving now are lost by design.
                busy        = 1'b1;
                reg_wr_en   = 1'b1;
                reg_wr_addr = addr_q + idx_q;
                reg_wr_data = buf_rd;
                if (idx_q == len_q - 8'd1) begin
                    state_next    = IDLE;
                    frame_ok_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Frame datapath: address, length, running checksum and buffer/commit index.
    always_ff @(posedge sysclk) begin
        if (!rstn) begin
            addr_q <= '0;
            len_q  <= '0;
            idx_q  <= '0;
            sum_q  <= '0;
        end else begin
            case (state)
                IDLE: idx_q <= '0;
                ADDR: begin
                    if (rx_valid) begin
                        addr_q <= rx_data;
                        sum_q  <= rx_data;
                    end
                end
                LEN: begin
                    if (rx_valid) begin
                        len_q <= rx_data;
                        sum_q <= sum_q + rx_data;
                    end
                end
                DATA: begin
                    if (rx_valid) begin
                        sum_q <= sum_q + rx_data;
                        idx_q <= idx_q + 8'd1;
                    end
                end
                CSUM:    idx_q <= '0;
                COMMIT:  idx_q <= idx_q + 8'd1;
                default: idx_q <= '0;
            endcase
        end
    end

    always_ff @(posedge sysclk) begin
        if (!rstn) begin
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            led       <= 4'h0;
        end else begin
            frame_ok  <= frame_ok_next;
            frame_err <= frame_err_next;
            if (reg_wr_en && reg_wr_addr == LED_ADDR) begin
                led <= reg_wr_data[3:0];
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb/tb_uart_cmd_parser.sv - self-checking bench for uart_cmd_parser
module tb_uart_cmd_parser;

    localparam int          MAXL = 16;
    localparam int          TMO  = 40;
    localparam logic [7:0]  LEDA = 8'h00;

    typedef logic [7:0] bq_t[$];

    logic       sysclk = 1'b0;
    logic       rstn;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       reg_wr_en;
    logic [7:0] reg_wr_addr;
    logic [7:0] reg_wr_data;
    logic       frame_ok;
    logic       frame_err;
    logic       busy;
    logic [3:0] led;

    int tests_run    = 0;
    int tests_failed = 0;

    int ncyc        = 0;
    int ok_cnt      = 0;
    int err_cnt     = 0;
    int last_ok_cyc = 0;
    int last_err_cyc = 0;
    int busy_cnt    = 0;
    int bad_busy    = 0;
    int         wr_cyc_q[$];
    logic [7:0] wr_addr_q[$];
    logic [7:0] wr_data_q[$];

    int         last_sent;
    logic [3:0] exp_led;

    always #5 sysclk = ~sysclk;

    uart_cmd_parser #(
        .MAX_LEN     (MAXL),
        .TIMEOUT_CYC (TMO),
        .LED_ADDR    (LEDA)
    ) dut (
        .sysclk      (sysclk),
        .rstn        (rstn),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .reg_wr_en   (reg_wr_en),
        .reg_wr_addr (reg_wr_addr),
        .reg_wr_data (reg_wr_data),
        .frame_ok    (frame_ok),
        .frame_err   (frame_err),
        .busy        (busy),
        .led         (led)
    );

    // Observer on the falling edge; events are stamped with the cycle number.
    always @(negedge sysclk) begin
        ncyc <= ncyc + 1;
        if (reg_wr_en === 1'b1) begin
            wr_cyc_q.push_back(ncyc + 1);
            wr_addr_q.push_back(reg_wr_addr);
            wr_data_q.push_back(reg_wr_data);
        end
        if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
        if (busy !== reg_wr_en) bad_busy <= bad_busy + 1;
        if (frame_ok === 1'b1) begin
            ok_cnt      <= ok_cnt + 1;
            last_ok_cyc <= ncyc + 1;
        end
        if (frame_err === 1'b1) begin
            err_cnt      <= err_cnt + 1;
            last_err_cyc <= ncyc + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge sysclk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data   = b;
        rx_valid  = 1'b1;
        last_sent = ncyc;
        @(posedge sysclk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    // Sends a frame, predicts its outcome from the frame rules and compares.
    task automatic run_frame(input string name, input bq_t fr, input int gap_idx, input int gap_len);
        int         sent[$];
        int         h, a, l, s, trig, nwr;
        bit         eok, eerr;
        logic [7:0] ea[$];
        logic [7:0] ed[$];
        int         b_ok, b_err, b_wr, b_busy, b_bad;
        b_ok   = ok_cnt;
        b_err  = err_cnt;
        b_wr   = wr_addr_q.size();
        b_busy = busy_cnt;
        b_bad  = bad_busy;
        for (int i = 0; i < fr.size(); i++) begin
            if (i == gap_idx) idle(gap_len);
            else idle($urandom_range(0, 2));
            send_byte(fr[i]);
            sent.push_back(last_sent);
        end
        h = 0;
        while (h < fr.size() && fr[h] != 8'hA5) h++;
        eok  = 1'b0;
        eerr = 1'b0;
        a    = fr[h+1];
        l    = fr[h+2];
        if (l == 0 || l > MAXL) begin
            eerr = 1'b1;
            trig = h + 2;
        end else begin
            s = a + l;
            for (int j = 0; j < l; j++) s += fr[h+3+j];
            trig = h + 3 + l;
            if ((s % 256) == fr[trig]) begin
                eok = 1'b1;
                for (int j = 0; j < l; j++) begin
                    ea.push_back(8'((a + j) % 256));
                    ed.push_back(fr[h+3+j]);
                    if (8'((a + j) % 256) == LEDA) exp_led = fr[h+3+j][3:0];
                end
            end else begin
                eerr = 1'b1;
            end
        end
        // Headers arriving while writes are issued must be ignored.
        if (eok) repeat (l) send_byte(8'hA5);
        idle(6);
        nwr = wr_addr_q.size() - b_wr;
        chk({name, " frame_ok count"}, ok_cnt - b_ok, 32'(eok));
        chk({name, " frame_err count"}, err_cnt - b_err, 32'(eerr));
        chk({name, " write count"}, nwr, ea.size());
        for (int j = 0; j < ea.size() && j < nwr; j++) begin
            chk({name, " write addr"}, 32'(wr_addr_q[b_wr+j]), 32'(ea[j]));
            chk({name, " write data"}, 32'(wr_data_q[b_wr+j]), 32'(ed[j]));
            chk({name, " write cycle"}, wr_cyc_q[b_wr+j], sent[trig] + 2 + j);
        end
        if (eok) chk({name, " frame_ok cycle"}, last_ok_cyc, sent[trig] + 2 + l);
        if (eerr) chk({name, " frame_err cycle"}, last_err_cyc, sent[trig] + 2);
        chk({name, " busy cycles"}, busy_cnt - b_busy, ea.size());
        chk({name, " busy vs wr_en"}, bad_busy - b_bad, 0);
        chk({name, " led"}, 32'(led), 32'(exp_led));
    endtask

    bq_t        f;
    int         mode, ra, rl, rs, w0, b0, e0, s0;
    logic [7:0] nz, pb;

    initial begin
        rstn     = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        exp_led  = 4'h0;
        repeat (3) @(posedge sysclk);
        #1;
        chk("reset reg_wr_en", 32'(reg_wr_en), 0);
        chk("reset reg_wr_addr", 32'(reg_wr_addr), 0);
        chk("reset reg_wr_data", 32'(reg_wr_data), 0);
        chk("reset frame_ok", 32'(frame_ok), 0);
        chk("reset frame_err", 32'(frame_err), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset led", 32'(led), 0);
        rstn = 1'b1;
        idle(2);

        f = '{8'hA5, 8'h10, 8'h02, 8'h33, 8'h44, 8'h89};
        run_frame("two_writes", f, -1, 0);
        f = '{8'hA5, 8'h00, 8'h01, 8'h0B, 8'h0C};
        run_frame("led_write", f, -1, 0);
        chk("led_write led B", 32'(led), 32'h0000_000B);
        f = '{8'hA5, 8'h10, 8'h02, 8'h33, 8'h44, 8'h88};
        run_frame("bad_csum", f, -1, 0);
        f = '{8'hA5, 8'h20, 8'h00};
        run_frame("len_zero", f, -1, 0);
        f = '{8'hA5, 8'h20, 8'h11};
        run_frame("len_over", f, -1, 0);
        f = '{8'hA5, 8'h20, 8'h01, 8'h07, 8'h28};
        run_frame("after_len_err", f, -1, 0);
        f = '{8'hA5, 8'hFF, 8'h02, 8'h01, 8'h02, 8'h04};
        run_frame("addr_wrap", f, -1, 0);
        f = '{8'h5A, 8'h00, 8'h33, 8'hA5, 8'h00, 8'h01, 8'h06, 8'h07};
        run_frame("noise_before_hdr", f, -1, 0);

        for (int k = 0; k < 24; k++) begin
            f = {};
            repeat ($urandom_range(0, 2)) begin
                nz = 8'($urandom);
                if (nz == 8'hA5) nz = 8'h5A;
                f.push_back(nz);
            end
            mode = $urandom_range(0, 9);
            ra   = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 255);
            if (mode == 0)      rl = 0;
            else if (mode == 1) rl = $urandom_range(MAXL + 1, 255);
            else                rl = $urandom_range(1, MAXL);
            f.push_back(8'hA5);
            f.push_back(8'(ra));
            f.push_back(8'(rl));
            if (mode >= 2) begin
                rs = ra + rl;
                for (int j = 0; j < rl; j++) begin
                    pb = 8'($urandom);
                    rs += pb;
                    f.push_back(pb);
                end
                if (mode == 2) rs += 1;
                f.push_back(8'(rs % 256));
            end
            run_frame("random", f, -1, 0);
        end

`ifdef UART_CMD_TIMEOUT_EN
        e0 = err_cnt;
        w0 = wr_addr_q.size();
        send_byte(8'hA5);
        send_byte(8'h10);
        s0 = last_sent;
        idle(TMO + 8);
        chk("timeout frame_err count", err_cnt - e0, 1);
        chk("timeout frame_err cycle", last_err_cyc, s0 + 2 + TMO);
        chk("timeout no writes", wr_addr_q.size() - w0, 0);
        f = '{8'hA5, 8'h00, 8'h01, 8'h05, 8'h06};
        run_frame("after_timeout", f, -1, 0);
        chk("after_timeout led 5", 32'(led), 32'h0000_0005);
`else
        f = '{8'hA5, 8'h10, 8'h02, 8'h33, 8'h44, 8'h89};
        run_frame("long_gap", f, 4, 5 * TMO);
`endif

        // Reset in the middle of the write burst.
        w0 = wr_addr_q.size();
        b0 = ok_cnt;
        e0 = err_cnt;
        f  = '{8'hA5, 8'h40, 8'h08};
        rs = 8'h40 + 8;
        for (int j = 0; j < 8; j++) begin
            pb = 8'($urandom);
            rs += pb;
            f.push_back(pb);
        end
        f.push_back(8'(rs % 256));
        for (int i = 0; i < f.size(); i++) send_byte(f[i]);
        idle(2);
        rstn = 1'b0;
        @(posedge sysclk);
        #1;
        rstn    = 1'b1;
        exp_led = 4'h0;
        chk("commit_reset busy", 32'(busy), 0);
        chk("commit_reset wr_en", 32'(reg_wr_en), 0);
        idle(12);
        chk("commit_reset writes", wr_addr_q.size() - w0, 3);
        chk("commit_reset frame_ok", ok_cnt - b0, 0);
        chk("commit_reset frame_err", err_cnt - e0, 0);
        chk("commit_reset led", 32'(led), 0);

        // Reset mid-frame: the tail bytes arrive in IDLE and do nothing.
        w0 = wr_addr_q.size();
        b0 = ok_cnt;
        e0 = err_cnt;
        send_byte(8'hA5);
        send_byte(8'h10);
        send_byte(8'h02);
        send_byte(8'h33);
        rstn = 1'b0;
        @(posedge sysclk);
        #1;
        rstn = 1'b1;
        send_byte(8'h44);
        send_byte(8'h89);
        idle(6);
        chk("frame_reset writes", wr_addr_q.size() - w0, 0);
        chk("frame_reset frame_ok", ok_cnt - b0, 0);
        chk("frame_reset frame_err", err_cnt - e0, 0);
        f = '{8'hA5, 8'h00, 8'h01, 8'h0B, 8'h0C};
        run_frame("after_reset", f, -1, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
